// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter for 32-bit CPU result words, LSB byte first, behind a small word FIFO.
// Define RESULT_TX_PARITY_EN to append an even-parity bit after the data bits of every frame.
module result_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_W       = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        data_valid,
   input  logic [31:0] data_in,
   output logic        in_ready,
   output logic        txd,
   output logic        busy,
   output logic        overflow
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state, state_nxt;
   logic [31:0]         mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_W:0]     count, count_nxt;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [2:0]          bit_idx;
   logic [1:0]          byte_idx;
   logic [31:0]         shreg;
   logic [7:0]          cur_byte;
   logic                push, pop, baud_done, txd_nxt;

   assign cur_byte  = shreg[7:0];
   assign push      = data_valid && in_ready;
   assign pop       = (state == S_IDLE) && (count != '0);
   assign baud_done = (baud_cnt == BAUD_LAST);

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (!push && pop)
         count_nxt = count - 1'b1;
   end

   always_comb begin
      state_nxt = state;
      txd_nxt   = 1'b1;
      case (state)
         S_IDLE: begin
            if (pop)
               state_nxt = S_START;
         end
         S_START: begin
            txd_nxt = 1'b0;
            if (baud_done)
               state_nxt = S_DATA;
         end
         S_DATA: begin
            txd_nxt = cur_byte[bit_idx];
            if (baud_done && (bit_idx == 3'd7)) begin
`ifdef RESULT_TX_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_STOP;
`endif
            end
         end
         S_PARITY: begin
            txd_nxt = ^cur_byte;
            if (baud_done)
               state_nxt = S_STOP;
         end
         S_STOP: begin
            if (baud_done)
               state_nxt = (byte_idx == 2'd3) ? S_IDLE : S_START;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   // txd and busy are registered from the current state, so both lag the FSM by one cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b1;
         overflow <= 1'b0;
         txd      <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
      end else begin
         txd      <= txd_nxt;
         busy     <= (state != S_IDLE) || (count != '0);
         count    <= count_nxt;
         in_ready <= (count_nxt != FULL_CNT);
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (data_valid && !in_ready)
            overflow <= 1'b1;
         if (baud_done || (state_nxt != state))
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + 1'b1;
         if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            bit_idx  <= '0;
         end
         if ((state == S_DATA) && baud_done)
            bit_idx <= bit_idx + 1'b1;
         if ((state == S_STOP) && baud_done && (byte_idx != 2'd3)) begin
            byte_idx <= byte_idx + 1'b1;
            shreg    <= shreg >> 8;
         end
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: a timeline model predicts txd/busy/in_ready/overflow per cycle.
// Define RESULT_TX_PARITY_EN for both bench and RTL to exercise the parity frame.
module tb_result_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef RESULT_TX_PARITY_EN
   localparam int FRAME = 11 * CPB;
`else
   localparam int FRAME = 10 * CPB;
`endif
   localparam int WORD_CYC = 4 * FRAME;

   logic        clock;
   logic        reset;
   logic        data_valid;
   logic [31:0] data_in;
   logic        in_ready;
   logic        txd;
   logic        busy;
   logic        overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model: each accepted word owns a line window starting at m_start.
   int          m_push  [128];
   int          m_start [128];
   logic [31:0] m_word  [128];
   int          m_n;
   int          next_free;
   logic        m_ovf;
   logic        smp [0:511];

   result_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .ADDR_W      (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .data_valid(data_valid),
      .data_in   (data_in),
      .in_ready  (in_ready),
      .txd       (txd),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void model_reset();
      m_n       = 0;
      next_free = -1000000;
      m_ovf     = 1'b0;
   endfunction

   // Words held in the FIFO after edge c: pushed by then, not yet popped (pop edge = start-1).
   function automatic int occupancy(int c);
      int n = 0;
      for (int i = 0; i < m_n; i++)
         if (m_push[i] <= c && m_start[i] - 1 > c) n++;
      return n;
   endfunction

   function automatic void model_push(logic [31:0] w);
      int s;
      if (occupancy(cyc - 1) == DEPTH) begin
         m_ovf = 1'b1;
      end else begin
         s = (cyc + 2 > next_free) ? cyc + 2 : next_free;
         m_push[m_n]  = cyc;
         m_start[m_n] = s;
         m_word[m_n]  = w;
         m_n++;
         next_free = s + WORD_CYC + 1;
      end
   endfunction

   function automatic logic exp_txd(int c);
      int off, b, slot;
      logic [31:0] sh;
      logic [7:0]  by;
      for (int i = 0; i < m_n; i++) begin
         if (c >= m_start[i] && c < m_start[i] + WORD_CYC) begin
            off  = c - m_start[i];
            b    = off / FRAME;
            slot = (off % FRAME) / CPB;
            sh   = m_word[i] >> (8 * b);
            by   = sh[7:0];
            if (slot == 0) return 1'b0;
            if (slot <= 8) begin
               sh = {24'd0, by} >> (slot - 1);
               return sh[0];
            end
`ifdef RESULT_TX_PARITY_EN
            if (slot == 9) return ^by;
`endif
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   function automatic logic exp_busy(int c);
      for (int i = 0; i < m_n; i++)
         if (m_push[i] + 1 <= c && c <= m_start[i] + WORD_CYC - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_ready(int c);
      return (occupancy(c) != DEPTH);
   endfunction

   task automatic step(input logic v, input logic [31:0] w);
      data_valid = v;
      data_in    = w;
      @(posedge clock);
      cyc++;
      if (v && reset) model_push(w);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({txd, in_ready, busy, overflow} !== 4'b1100) begin
         n_bad++;
         $display("FAIL reset_state: got txd/rdy/busy/ovf=%b required 1100", {txd, in_ready, busy, overflow});
      end
      for (int k = 0; k < 100; k++) begin
         step(1'b0, $urandom);
         n_cmp++;
         if (txd !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle cyc %0d: got txd=%b busy=%b required txd=1 busy=0", cyc, txd, busy);
         end
      end
   endtask

   task automatic test_single();
      int n0, first_low, fall;
      logic [31:0] w = 32'h12345678;
      logic [7:0]  got, want;
      do_reset();
      step(1'b1, w);
      n0 = cyc;
      first_low = -1;
      fall = -1;
      for (int k = 1; k <= 180; k++) begin
         step(1'b0, $urandom);
         smp[k] = txd;
         n_cmp++;
         if (txd !== exp_txd(cyc) || busy !== exp_busy(cyc)) begin
            n_bad++;
            $display("FAIL single_line cyc %0d: got txd=%b busy=%b required txd=%b busy=%b",
                     cyc, txd, busy, exp_txd(cyc), exp_busy(cyc));
         end
         if (first_low < 0 && txd == 1'b0) first_low = cyc;
         if (fall < 0 && busy == 1'b0) fall = cyc;
      end
      n_cmp++;
      if (first_low != n0 + 2) begin
         n_bad++;
         $display("FAIL single_latency: got txd low %0d cycles after push required 2", first_low - n0);
      end
      n_cmp++;
      if (fall != n0 + 162) begin
         n_bad++;
         $display("FAIL single_busy_fall: got %0d cycles after push required 162", fall - n0);
      end
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 8; j++) got[j] = smp[2 + FRAME * b + CPB * (1 + j) + 1];
         want = w[8 * b +: 8];
         n_cmp++;
         if (got !== want || smp[2 + FRAME * b + FRAME - 2] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_byte%0d: got 0x%02h stop=%b required 0x%02h stop=1",
                     b, got, smp[2 + FRAME * b + FRAME - 2], want);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      do_reset();
      step(1'b1, 32'hFFFFFFFF);
      n0 = cyc;
      step(1'b1, 32'h00000000);
      smp[1] = txd;
      for (int k = 2; k <= 340; k++) begin
         step(1'b0, $urandom);
         smp[k] = txd;
         n_cmp++;
         if (txd !== exp_txd(cyc) || busy !== exp_busy(cyc)) begin
            n_bad++;
            $display("FAIL b2b_line cyc %0d: got txd=%b busy=%b required txd=%b busy=%b",
                     cyc, txd, busy, exp_txd(cyc), exp_busy(cyc));
         end
      end
      // word 0 occupies samples 2..161, one idle high at 162, word 1 starts at 163
      n_cmp++;
      if ({smp[161], smp[162], smp[163]} !== 3'b110) begin
         n_bad++;
         $display("FAIL b2b_gap: got stop/gap/start=%b required 110", {smp[161], smp[162], smp[163]});
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w;
      do_reset();
      step(1'b1, $urandom);
      for (int i = 0; i < 5; i++) begin
         w = $urandom;
         step(1'b1, w);
         if (i == 3) begin
            n_cmp++;
            if (in_ready !== 1'b0 || overflow !== 1'b0) begin
               n_bad++;
               $display("FAIL ovf_full: got in_ready=%b overflow=%b required 0 0", in_ready, overflow);
            end
         end
      end
      n_cmp++;
      if (overflow !== 1'b1 || m_n != 5) begin
         n_bad++;
         $display("FAIL ovf_flag: got overflow=%b required 1", overflow);
      end
      for (int k = 0; k < 5 * (WORD_CYC + 1) + 10; k++) begin
         step(1'b0, $urandom);
         n_cmp++;
         if (txd !== exp_txd(cyc) || in_ready !== exp_ready(cyc) || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_line cyc %0d: got txd=%b rdy=%b ovf=%b required txd=%b rdy=%b ovf=1",
                     cyc, txd, in_ready, overflow, exp_txd(cyc), exp_ready(cyc));
         end
      end
   endtask

   task automatic test_reset_mid();
      int target;
      do_reset();
      step(1'b1, 32'hC3C3C3C3);
      target = cyc + 2 + 2 * FRAME + 3 * CPB;
      while (cyc < target) step(1'b0, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({txd, in_ready, busy, overflow} !== 4'b1100) begin
         n_bad++;
         $display("FAIL midreset_state: got txd/rdy/busy/ovf=%b required 1100", {txd, in_ready, busy, overflow});
      end
      step(1'b0, 32'd0);
      step(1'b0, 32'd0);
      reset = 1'b1;
      step(1'b1, 32'hA5A5A5A5);
      for (int k = 0; k < 175; k++) begin
         step(1'b0, $urandom);
         n_cmp++;
         if (txd !== exp_txd(cyc) || busy !== exp_busy(cyc)) begin
            n_bad++;
            $display("FAIL midreset_line cyc %0d: got txd=%b busy=%b required txd=%b busy=%b",
                     cyc, txd, busy, exp_txd(cyc), exp_busy(cyc));
         end
      end
   endtask

   task automatic test_random();
      int burst, gap;
      logic v;
      do_reset();
      for (int r = 0; r < 10; r++) begin
         burst = $urandom_range(1, 6);
         gap   = $urandom_range(0, 400);
         for (int k = 0; k < burst + gap; k++) begin
            v = (k < burst) || ($urandom_range(0, 99) < 2);
            step(v, $urandom);
            n_cmp++;
            if (txd !== exp_txd(cyc) || busy !== exp_busy(cyc) ||
                in_ready !== exp_ready(cyc) || overflow !== m_ovf) begin
               n_bad++;
               $display("FAIL random cyc %0d: got txd=%b busy=%b rdy=%b ovf=%b required %b %b %b %b",
                        cyc, txd, busy, in_ready, overflow,
                        exp_txd(cyc), exp_busy(cyc), exp_ready(cyc), m_ovf);
            end
         end
      end
      while (exp_busy(cyc) || cyc < next_free) begin
         step(1'b0, $urandom);
         n_cmp++;
         if (txd !== exp_txd(cyc) || busy !== exp_busy(cyc)) begin
            n_bad++;
            $display("FAIL random_drain cyc %0d: got txd=%b busy=%b required txd=%b busy=%b",
                     cyc, txd, busy, exp_txd(cyc), exp_busy(cyc));
         end
      end
   endtask

`ifdef RESULT_TX_PARITY_EN
   task automatic test_parity();
      logic [3:0] got;
      do_reset();
      step(1'b1, 32'h00000103);
      for (int k = 1; k <= 180; k++) begin
         step(1'b0, 32'd0);
         smp[k] = txd;
         n_cmp++;
         if (txd !== exp_txd(cyc)) begin
            n_bad++;
            $display("FAIL parity_line cyc %0d: got txd=%b required %b", cyc, txd, exp_txd(cyc));
         end
      end
      for (int b = 0; b < 4; b++) got[b] = smp[2 + 44 * b + 9 * CPB + 1];
      n_cmp++;
      if (got !== 4'b0010) begin
         n_bad++;
         $display("FAIL parity_bits: got b3..b0=%b required 0010", got);
      end
      n_cmp++;
      if (smp[45] !== 1'b1 || smp[46] !== 1'b0) begin
         n_bad++;
         $display("FAIL parity_frame_len: got stop=%b next_start=%b required 1 0", smp[45], smp[46]);
      end
   endtask
`endif

   initial begin
      reset      = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_random();
`ifdef RESULT_TX_PARITY_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
